opc5_bus_responder: RTL and testbench

//  Target side of the OPC5 single-cycle memory bus (data/address/rnw, no wait states).

---
 rtl/opc5_bus_responder.sv | 164 ++++++++++++++++
 tb/tb_opc5_bus_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opc5_bus_responder.sv
// opc5_bus_responder
//   Target side of the OPC5 zero-wait-state memory bus. Holds program/data
//   RAM plus a 4-word memory-mapped I/O page at IO_BASE:
//     +0 STATUS  R: {11'b0, ovf, tmr_exp, rx_full, tx_empty, tx_full}
//                W: bit3=1 clears tmr_exp, bit4=1 clears ovf
//     +1 TXDATA  W: push into TX FIFO (dropped and ovf set when full), R: 0
//     +2 RXDATA  R: RX holding register; a read cycle clears rx_full
//     +3 TIMER   R: current count, W: reload = count = write data
//   Reads are combinational from address; writes land on the edge that
//   ends the rnw=0 cycle. Unmapped reads return 0, unmapped writes vanish.
// Ports
//   clk, reset          bus clock; asynchronous active-high reset
//   address, rnw        bus address and direction (1 = read)
//   data                shared tristate bus, driven here only while rnw=1
//   tx_data/valid/ready TX FIFO head streaming out (valid/ready)
//   rx_data/valid/ready RX word offered in; rx_ready = holding reg empty
module opc5_bus_responder #(
  parameter int          RAM_AW    = 11,
  parameter logic [15:0] IO_BASE   = 16'hFE00,
  parameter int          TX_DEPTH  = 4,
  parameter              INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        rnw,
  inout  wire  [15:0] data,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  localparam int          PW        = $clog2(TX_DEPTH);
  localparam int          RAM_WORDS = 1 << RAM_AW;
  localparam logic [PW:0] FIFO_FULL = TX_DEPTH[PW:0];

  // ---------------------------------------------------------------- decode
  logic        ram_sel, io_sel;
  logic [1:0]  io_reg;
  logic        wr_status, wr_tx, rd_rx, wr_timer;
  logic [15:0] wdata;

  assign ram_sel   = (address >> RAM_AW) == 16'd0;
  assign io_sel    = address[15:2] == IO_BASE[15:2];
  assign io_reg    = address[1:0];
  assign wdata     = data;
  assign wr_status = io_sel && !rnw && io_reg == 2'd0;
  assign wr_tx     = io_sel && !rnw && io_reg == 2'd1;
  assign rd_rx     = io_sel &&  rnw && io_reg == 2'd2;
  assign wr_timer  = io_sel && !rnw && io_reg == 2'd3;

  // ------------------------------------------------------------------- RAM
  logic [15:0] ram [0:RAM_WORDS-1];

  // Not reset: program/data image survives a reset.
  always_ff @(posedge clk) begin
    if (ram_sel && !rnw) ram[address[RAM_AW-1:0]] <= wdata;
  end

  // --------------------------------------------------------------- TX FIFO
  logic [15:0]   fifo [0:TX_DEPTH-1];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   tx_count;
  logic          tx_full, tx_empty, pop, push_ok, ovf;

  assign tx_full  = tx_count == FIFO_FULL;
  assign tx_empty = tx_count == '0;
  assign tx_valid = !tx_empty;
  assign tx_data  = tx_empty ? 16'h0000 : fifo[rd_ptr];
  assign pop      = tx_valid && tx_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO survives.
  assign push_ok  = wr_tx && (!tx_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_count <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: ;
      endcase
      if (wr_tx && !push_ok)          ovf <= 1'b1;
      else if (wr_status && wdata[4]) ovf <= 1'b0;
    end
  end

  // ------------------------------------------------------ RX holding register
  logic        rx_full;
  logic [15:0] rx_hold;

  assign rx_ready = !rx_full;

  // Capture requires rx_full=0 and a clearing read requires rx_full=1,
  // so the two branches never compete.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_full <= 1'b0;
      rx_hold <= 16'h0000;
    end else if (rx_valid && !rx_full) begin
      rx_full <= 1'b1;
      rx_hold <= rx_data;
    end else if (rd_rx) begin
      rx_full <= 1'b0;
    end
  end

  // ----------------------------------------------------------------- timer
  logic [15:0] reload, count;
  logic        tmr_exp, expire;

  // A CPU load on the expiry edge wins and suppresses the expiry.
  assign expire = reload != 16'd0 && count == 16'd1 && !wr_timer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload  <= 16'd0;
      count   <= 16'd0;
      tmr_exp <= 1'b0;
    end else if (wr_timer) begin
      reload  <= wdata;
      count   <= wdata;
      tmr_exp <= 1'b0;
    end else begin
      if (reload != 16'd0) count <= (count == 16'd1) ? reload : count - 16'd1;
      // Expiry beats a simultaneous STATUS clear.
      if (expire)                     tmr_exp <= 1'b1;
      else if (wr_status && wdata[3]) tmr_exp <= 1'b0;
    end
  end

  // ------------------------------------------------------------- read path
  logic [15:0] status, rd_data;

  assign status = {11'd0, ovf, tmr_exp, rx_full, tx_empty, tx_full};

  always_comb begin
    rd_data = 16'h0000;
    if (ram_sel) begin
      rd_data = ram[address[RAM_AW-1:0]];
    end else if (io_sel) begin
      case (io_reg)
        2'd0:    rd_data = status;
        2'd2:    rd_data = rx_hold;
        2'd3:    rd_data = count;
        default: rd_data = 16'h0000;
      endcase
    end
  end

  assign data = rnw ? rd_data : 16'hzzzz;

endmodule

// File: tb/tb_opc5_bus_responder.sv
// tb_opc5_bus_responder
//   Drives bus cycles from negedge to negedge (inputs settle mid-cycle,
//   observations taken 1 time unit after the negedge). Expected values come
//   from a behavioural model: a queue for the TX FIFO, flags for the status
//   bits, an associative array for RAM and closed-form timer arithmetic.
module tb_opc5_bus_responder;
  localparam logic [15:0] IO    = 16'hFE00;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] address = 16'h4000;
  logic        rnw = 1'b1;
  wire  [15:0] data;
  logic [15:0] tb_data = 16'h0000;
  logic        tb_drive = 1'b0;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] rx_data = 16'h0000;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  assign data = tb_drive ? tb_data : 16'hzzzz;

  opc5_bus_responder dut (
    .clk(clk), .reset(reset), .address(address), .rnw(rnw), .data(data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model
  logic [15:0] txq[$];
  bit          m_ovf = 1'b0, m_exp = 1'b0, m_rx_full = 1'b0;
  logic [15:0] ram_m [int];

  function automatic logic [15:0] model_status();
    return {11'd0, m_ovf, m_exp, m_rx_full, txq.size() == 0, txq.size() == DEPTH};
  endfunction

  task automatic bus_idle();
    @(negedge clk); address = 16'h4000; rnw = 1'b1; tb_drive = 1'b0; #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk); address = a; rnw = 1'b0; tb_data = d; tb_drive = 1'b1; #1;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] v);
    @(negedge clk); address = a; rnw = 1'b1; tb_drive = 1'b0; #1; v = data;
  endtask

  // write cycle with nobody driving the bus
  task automatic bus_float(input logic [15:0] a);
    @(negedge clk); address = a; rnw = 1'b0; tb_drive = 1'b0; #1;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    reset = 1'b1; #3;
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
    n_cmp++; if (tx_data !== 16'h0000) begin n_bad++; $display("FAIL reset_tx_data: got %h want 0000", tx_data); end
    bus_read(IO, v);
    n_cmp++; if (v !== 16'h0002) begin n_bad++; $display("FAIL reset_status: got %h want 0002", v); end
    @(negedge clk); reset = 1'b0;
    bus_read(IO + 16'd3, v);
    n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL reset_timer: got %h want 0000", v); end
    $display("test_reset done");
  endtask

  task automatic test_ram();
    logic [15:0] v, a, d;
    bus_write(16'h0005, 16'h1234); ram_m[5] = 16'h1234;
    bus_read(16'h0005, v);
    n_cmp++; if (v !== 16'h1234) begin n_bad++; $display("FAIL ram_0005: got %h want 1234", v); end
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom_range(6, 2047)); d = 16'($urandom);
      bus_write(a, d); ram_m[int'(a)] = d;
    end
    foreach (ram_m[k]) begin
      bus_read(16'(k), v);
      n_cmp++; if (v !== ram_m[k]) begin n_bad++; $display("FAIL ram_read @%h: got %h want %h", 16'(k), v, ram_m[k]); end
    end
    // unmapped write must not alias onto RAM
    bus_write(16'h0805, 16'hDEAD);
    bus_read(16'h0005, v);
    n_cmp++; if (v !== 16'h1234) begin n_bad++; $display("FAIL ram_alias: got %h want 1234", v); end
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: a = 16'h4000;
        1: a = 16'h0800;
        2: a = 16'hFDFF;
        3: a = 16'hFE04;
        4: a = 16'hFFFF;
        default: a = 16'($urandom_range(16'h0800, 16'hFDFF));
      endcase
      bus_read(a, v);
      n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL unmapped @%h: got %h want 0000", a, v); end
    end
    $display("test_ram done");
  endtask

  task automatic test_tx_overflow();
    logic [15:0] v, w;
    tx_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) begin
        w = (r == 0) ? 16'(16'hA1 + i) : 16'($urandom);
        bus_write(IO + 16'd1, w);
        n_cmp++; if (tx_valid !== (i > 0)) begin n_bad++; $display("FAIL tx_latency w%0d: got %b want %b", i, tx_valid, i > 0); end
        if (i > 0) begin
          n_cmp++; if (tx_data !== txq[0]) begin n_bad++; $display("FAIL tx_head w%0d: got %h want %h", i, tx_data, txq[0]); end
        end
        if (txq.size() < DEPTH) txq.push_back(w); else m_ovf = 1'b1;
      end
      bus_read(IO, v);
      n_cmp++; if (v !== model_status()) begin n_bad++; $display("FAIL tx_full_status: got %h want %h", v, model_status()); end
      for (int j = 0; j < DEPTH + 2; j++) begin
        bus_idle();
        if (txq.size() > 0) begin
          n_cmp++; if (tx_valid !== 1'b1 || tx_data !== txq[0]) begin n_bad++; $display("FAIL tx_drain %0d: got %b/%h want 1/%h", j, tx_valid, tx_data, txq[0]); end
        end else begin
          n_cmp++; if (tx_valid !== 1'b0 || tx_data !== 16'h0000) begin n_bad++; $display("FAIL tx_drain_empty %0d: got %b/%h want 0/0000", j, tx_valid, tx_data); end
        end
        tx_ready = 1'b1;
        if (txq.size() > 0) void'(txq.pop_front());
      end
      tx_ready = 1'b0;
      bus_write(IO, 16'h0010); m_ovf = 1'b0;
      bus_read(IO, v);
      n_cmp++; if (v !== model_status()) begin n_bad++; $display("FAIL ovf_clear: got %h want %h", v, model_status()); end
    end
    $display("test_tx_overflow done");
  endtask

  task automatic test_back_to_back();
    logic [15:0] v, d;
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      d = 16'($urandom); bus_write(IO + 16'd1, d); txq.push_back(d);
    end
    // full FIFO: push and pop on the same edge
    d = 16'($urandom); bus_write(IO + 16'd1, d); tx_ready = 1'b1;
    void'(txq.pop_front()); txq.push_back(d);
    @(posedge clk); #1; tx_ready = 1'b0;
    bus_read(IO, v);
    n_cmp++; if (v !== model_status()) begin n_bad++; $display("FAIL pushpop_full_status: got %h want %h", v, model_status()); end
    for (int j = 0; j < DEPTH + 1; j++) begin
      bus_idle();
      if (txq.size() > 0) begin
        n_cmp++; if (tx_valid !== 1'b1 || tx_data !== txq[0]) begin n_bad++; $display("FAIL pushpop_order %0d: got %b/%h want 1/%h", j, tx_valid, tx_data, txq[0]); end
      end else begin
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL pushpop_empty: got %b want 0", tx_valid); end
      end
      tx_ready = 1'b1;
      if (txq.size() > 0) void'(txq.pop_front());
    end
    // empty FIFO with tx_ready high: word must still enter
    d = 16'($urandom); bus_write(IO + 16'd1, d);
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL empty_push_same_cycle: got %b want 0", tx_valid); end
    bus_idle();
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== d) begin n_bad++; $display("FAIL empty_push_next: got %b/%h want 1/%h", tx_valid, tx_data, d); end
    bus_idle();
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL empty_push_popped: got %b want 0", tx_valid); end
    tx_ready = 1'b0;
    $display("test_back_to_back done");
  endtask

  task automatic test_rx();
    logic [15:0] v, w1, w2;
    for (int r = 0; r < 2; r++) begin
      w1 = (r == 0) ? 16'hBEEF : (16'($urandom) | 16'h0001);
      w2 = ~w1;
      bus_idle();
      n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL rx_ready_idle: got %b want 1", rx_ready); end
      rx_data = w1; rx_valid = 1'b1;
      bus_idle(); m_rx_full = 1'b1;
      n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL rx_ready_after_accept: got %b want 0", rx_ready); end
      rx_data = w2;  // offered while full: must not be taken yet
      bus_read(IO, v);
      n_cmp++; if (v !== model_status()) begin n_bad++; $display("FAIL rx_status: got %h want %h", v, model_status()); end
      bus_float(IO + 16'd2);
      n_cmp++; if (data === w1) begin n_bad++; $display("FAIL bus_not_released: got %h want high-Z", data); end
      bus_read(IO + 16'd2, v);
      n_cmp++; if (v !== w1) begin n_bad++; $display("FAIL rx_read1: got %h want %h", v, w1); end
      bus_idle();
      n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL rx_cleared: got %b want 1", rx_ready); end
      bus_idle(); rx_valid = 1'b0;
      bus_read(IO + 16'd2, v);
      n_cmp++; if (v !== w2 || rx_ready !== 1'b0) begin n_bad++; $display("FAIL rx_read2: got %h/%b want %h/0", v, rx_ready, w2); end
      bus_idle(); m_rx_full = 1'b0;
      n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL rx_cleared2: got %b want 1", rx_ready); end
    end
    $display("test_rx done");
  endtask

  task automatic test_timer();
    logic [15:0] v;
    int R, R2;
    bit e, clr;
    for (int r = 0; r < 3; r++) begin
      R = (r == 0) ? 3 : $urandom_range(3, 7);
      bus_write(IO + 16'd3, 16'(R));  // load edge = edge 0
      e = 1'b0;
      // cycle c observes state after edge c-1; its action lands on edge c
      for (int c = 1; c <= 3 * R + 1; c++) begin
        clr = (c == R + 2) || (c == 3 * R);
        if (clr) begin
          bus_write(IO, 16'h0008);
        end else if (c == R || c == R + 1 || c == R + 3 || c == 3 * R + 1 || (c % 3) != 1) begin
          bus_read(IO, v);
          n_cmp++; if (v[3] !== e) begin n_bad++; $display("FAIL tmr_exp R=%0d c=%0d: got %b want %b", R, c, v[3], e); end
        end else begin
          bus_read(IO + 16'd3, v);
          n_cmp++; if (v !== 16'(R - ((c - 1) % R))) begin n_bad++; $display("FAIL timer_count R=%0d c=%0d: got %0d want %0d", R, c, v, R - ((c - 1) % R)); end
        end
        if (clr) e = 1'b0;
        if (c % R == 0) e = 1'b1;
      end
    end
    // load on the expiry edge: load wins, no expiry flag
    R = $urandom_range(3, 6); R2 = $urandom_range(3, 9);
    bus_write(IO + 16'd3, 16'(R));
    for (int c = 1; c < R; c++) bus_read(IO + 16'd3, v);
    bus_write(IO + 16'd3, 16'(R2));
    bus_read(IO, v);
    n_cmp++; if (v[3] !== 1'b0) begin n_bad++; $display("FAIL tmr_load_priority: got %b want 0", v[3]); end
    bus_read(IO + 16'd3, v);
    n_cmp++; if (v !== 16'(R2 - 1)) begin n_bad++; $display("FAIL tmr_reload_count: got %0d want %0d", v, R2 - 1); end
    bus_write(IO + 16'd3, 16'd0);
    for (int c = 0; c < 3; c++) bus_read(IO + 16'd3, v);
    n_cmp++; if (v !== 16'd0) begin n_bad++; $display("FAIL tmr_disabled: got %0d want 0", v); end
    bus_read(IO, v);
    n_cmp++; if (v !== model_status()) begin n_bad++; $display("FAIL tmr_disabled_status: got %h want %h", v, model_status()); end
    $display("test_timer done");
  endtask

  task automatic test_reset_mid();
    logic [15:0] v, d;
    tx_ready = 1'b0;
    rx_data = 16'($urandom); rx_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d = 16'($urandom); bus_write(IO + 16'd1, d); txq.push_back(d);
    end
    bus_write(IO + 16'd3, 16'd2);
    bus_idle(); bus_idle(); rx_valid = 1'b0;
    bus_read(IO, v);
    n_cmp++; if (v !== 16'h000C) begin n_bad++; $display("FAIL pre_reset_status: got %h want 000C", v); end
    // assert reset between edges, with STATUS on the bus
    @(negedge clk); address = IO; rnw = 1'b1; tb_drive = 1'b0; #2;
    reset = 1'b1; #1;
    txq.delete(); m_ovf = 1'b0; m_exp = 1'b0; m_rx_full = 1'b0;
    n_cmp++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || tx_data !== 16'h0000) begin n_bad++; $display("FAIL mid_reset_ports: got %b/%b/%h want 0/1/0000", tx_valid, rx_ready, tx_data); end
    n_cmp++; if (data !== 16'h0002) begin n_bad++; $display("FAIL mid_reset_status: got %h want 0002", data); end
    @(negedge clk); reset = 1'b0;
    bus_read(IO + 16'd3, v);
    n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL mid_reset_timer: got %h want 0000", v); end
    bus_read(16'h0005, v);
    n_cmp++; if (v !== ram_m[5]) begin n_bad++; $display("FAIL ram_retained: got %h want %h", v, ram_m[5]); end
    bus_read(IO, v);
    n_cmp++; if (v !== model_status()) begin n_bad++; $display("FAIL post_reset_status: got %h want %h", v, model_status()); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_ram();
    test_tx_overflow();
    test_back_to_back();
    test_rx();
    test_timer();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
